// File: rtl/trace_dump_ctrl_if.sv
// Bus bundle between the trace dump controller and its surroundings:
// command processor, capture engine, the three sample RAMs and the UART.
interface trace_dump_ctrl_if #(
  parameter int AW = 9
);
  logic          dump_req;
  logic [1:0]    dump_ch;
  logic          cap_done;
  logic [AW-1:0] trace_end;
  logic          cap_en;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [7:0]    rdata_ch1;
  logic [7:0]    rdata_ch2;
  logic [7:0]    rdata_ch3;
  logic          tx_done;
  logic [2:0]    ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    tx_data;
  logic          trmt;
  logic          dump_busy;
  logic          dump_done;
  logic          dump_nak;
  logic          clr_cap_done;

  // Controller side
  modport slave (
    input  dump_req, dump_ch, cap_done, trace_end,
    input  cap_en, cap_we, cap_addr,
    input  rdata_ch1, rdata_ch2, rdata_ch3, tx_done,
    output ram_en, ram_we, ram_addr, tx_data, trmt,
    output dump_busy, dump_done, dump_nak, clr_cap_done
  );

  // Environment side
  modport master (
    output dump_req, dump_ch, cap_done, trace_end,
    output cap_en, cap_we, cap_addr,
    output rdata_ch1, rdata_ch2, rdata_ch3, tx_done,
    input  ram_en, ram_we, ram_addr, tx_data, trmt,
    input  dump_busy, dump_done, dump_nak, clr_cap_done
  );
endinterface

// File: rtl/trace_dump_ctrl.sv
// Trace dump controller: arbitrates the sample RAMs between the capture
// engine and the dump path, and streams one channel of a captured trace,
// oldest sample first, to the UART transmitter.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   S_IDLE    | capture engine owns the RAMs (combinational passthrough)
//   S_READ    | enable selected channel RAM at rd_ptr
//   S_WAIT    | RAM data returns; latch it into tx_data
//   S_SEND    | one-cycle transmit strobe
//   S_WAIT_TX | wait for UART byte complete, advance or finish
//
// Dropping cap_done in any busy state aborts straight back to S_IDLE
// without a done pulse; pointers are left stale and tx_data is held.
module trace_dump_ctrl #(
  parameter int DEPTH = 512
) (
  input logic               clk,
  input logic               rst_n,
  trace_dump_ctrl_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_ch_sel;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_tx_data;
  logic               r_dump_busy;

  logic               w_load;
  logic               w_capture;
  logic               w_advance;
  logic               w_nak;
  logic               w_done;
  logic               w_trmt;
  logic               w_last;
  logic [2:0]         w_ram_en;
  logic               w_ram_we;
  logic [AW-1:0]      w_ram_addr;
  logic [2:0]         w_onehot;
  logic [7:0]         w_rdata;

  // Decode the latched channel into a RAM enable and a read-data select
  always_comb begin
    w_onehot = 3'b000;
    w_rdata  = bus.rdata_ch1;
    case (r_ch_sel)
      2'b00: begin
        w_onehot = 3'b001;
        w_rdata  = bus.rdata_ch1;
      end
      2'b01: begin
        w_onehot = 3'b010;
        w_rdata  = bus.rdata_ch2;
      end
      2'b10: begin
        w_onehot = 3'b100;
        w_rdata  = bus.rdata_ch3;
      end
      default: begin
        w_onehot = 3'b000;
        w_rdata  = bus.rdata_ch1;
      end
    endcase
  end

  assign w_last = (r_cnt == CNT_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode, RAM port mux and strobes
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_capture  = 1'b0;
    w_advance  = 1'b0;
    w_nak      = 1'b0;
    w_done     = 1'b0;
    w_trmt     = 1'b0;
    w_ram_en   = 3'b000;
    w_ram_we   = 1'b0;
    w_ram_addr = r_rd_ptr;
    case (r_state)
      S_IDLE: begin
        w_ram_en   = {3{bus.cap_en}};
        w_ram_we   = bus.cap_we;
        w_ram_addr = bus.cap_addr;
        if (bus.dump_req) begin
          if (bus.cap_done && (bus.dump_ch != 2'b11)) begin
            w_load = 1'b1;
            w_next = S_READ;
          end else begin
            w_nak = 1'b1;
          end
        end
      end
      S_READ: begin
        w_ram_en = w_onehot;
        w_next   = bus.cap_done ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (bus.cap_done) begin
          w_capture = 1'b1;
          w_next    = S_SEND;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SEND: begin
        w_trmt = 1'b1;
        w_next = bus.cap_done ? S_WAIT_TX : S_IDLE;
      end
      S_WAIT_TX: begin
        if (!bus.cap_done) begin
          w_next = S_IDLE;
        end else if (bus.tx_done) begin
          w_advance = 1'b1;
          if (w_last) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_next = S_READ;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Dump datapath: channel latch, read pointer, byte count, tx byte, busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_sel    <= 2'b00;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_tx_data   <= 8'h00;
      r_dump_busy <= 1'b0;
    end else begin
      if (w_load) begin
        r_ch_sel <= bus.dump_ch;
        r_rd_ptr <= bus.trace_end + AW'(1);
        r_cnt    <= '0;
      end else if (w_advance) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_tx_data <= w_rdata;
      end
      r_dump_busy <= (w_next != S_IDLE);
    end
  end

  assign bus.ram_en       = w_ram_en;
  assign bus.ram_we       = w_ram_we;
  assign bus.ram_addr     = w_ram_addr;
  assign bus.tx_data      = r_tx_data;
  assign bus.trmt         = w_trmt;
  assign bus.dump_busy    = r_dump_busy;
  assign bus.dump_done    = w_done;
  assign bus.clr_cap_done = w_done;
  assign bus.dump_nak     = w_nak;

endmodule
